// File: rtl/algo_1rw1w_a107_rdq.sv
// ---------------------------------------------------------------------------
// algo_1rw1w_a107_rdq
//
// Read-data queue for the 1rw1w memory top. Host reads are accepted only
// while there is credit: the sum of reads in flight and responses waiting
// must stay below DEPTH. Each accepted read pushes its tag into an in-order
// tag FIFO. Each memory return pops the oldest tag and joins that tag with
// the returned data, ECC flags and physical address. The result goes into a
// response queue whose head is presented on registered out_* ports.
//
// Optional feature (macro ALGO_RDQ_ERRCNT_EN):
//   defined   - serr_cnt / derr_cnt count queued returns that carry
//               rw_serr / rw_derr, saturating at 16'hFFFF
//   undefined - serr_cnt / derr_cnt are tied to zero and no counter
//               registers exist
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   ready                 memory side can accept a read this cycle
//   hst_read, hst_tag     host read request and its tag
//   hst_rdy               request accepted this cycle (combinational)
//   rw_read               read issued to memory
//   rw_vld, rw_dout       read return strobe and data
//   rw_serr, rw_derr      single / double bit error flags of the return
//   rw_padr               physical address of the return
//   out_vld, out_rdy      consumer handshake
//   out_dout, out_tag     queued data and matching host tag
//   out_serr, out_derr    queued error flags
//   out_padr              queued physical address
//   orphan                sticky: a return arrived with no read in flight
//   serr_cnt, derr_cnt    error counters (zero unless ALGO_RDQ_ERRCNT_EN)
// ---------------------------------------------------------------------------
module algo_1rw1w_a107_rdq #(
    parameter int WIDTH   = 32,
    parameter int BITPADR = 17,
    parameter int DEPTH   = 8,
    parameter int BITDPTH = 3,
    parameter int TAGW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ready,
    input  logic               hst_read,
    input  logic [TAGW-1:0]    hst_tag,
    output logic               hst_rdy,
    output logic               rw_read,
    input  logic               rw_vld,
    input  logic [WIDTH-1:0]   rw_dout,
    input  logic               rw_serr,
    input  logic               rw_derr,
    input  logic [BITPADR-1:0] rw_padr,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [WIDTH-1:0]   out_dout,
    output logic [TAGW-1:0]    out_tag,
    output logic               out_serr,
    output logic               out_derr,
    output logic [BITPADR-1:0] out_padr,
    output logic               orphan,
    output logic [15:0]        serr_cnt,
    output logic [15:0]        derr_cnt
);

    localparam int CNTW = BITDPTH + 1;
    localparam int SUMW = BITDPTH + 2;

    typedef struct packed {
        logic [WIDTH-1:0]   dout;
        logic [TAGW-1:0]    tag;
        logic               serr;
        logic               derr;
        logic [BITPADR-1:0] padr;
    } respEntryT;

    // Tag FIFO state
    logic [TAGW-1:0]    tagMem [DEPTH];
    logic [BITDPTH-1:0] tagWrPtr;
    logic [BITDPTH-1:0] tagRdPtr;
    logic [CNTW-1:0]    outstanding;

    // Response queue state. The output register is the first queue slot, so
    // the backing memory only ever holds entries behind it.
    respEntryT          respMem [DEPTH];
    logic [BITDPTH-1:0] respWrPtr;
    logic [BITDPTH-1:0] respRdPtr;
    logic [CNTW-1:0]    memCount;
    logic               outVldR;
    respEntryT          outReg;
    logic               orphanR;

    // Combinational controls
    logic [SUMW-1:0] busy;
    logic [SUMW-1:0] credit;
    logic            retAccept;
    logic            retOrphan;
    logic            outFree;
    logic            loadFromMem;
    logic            loadBypass;
    logic            memPush;
    respEntryT       newEntry;

    // Pointer increment that wraps modulo DEPTH even when DEPTH is not a
    // power of two.
    function automatic logic [BITDPTH-1:0] nextPtr(input logic [BITDPTH-1:0] p);
        return (p == BITDPTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit and issue control. hst_rdy is also gated by rst so nothing can be
    // issued while reset is held. A return is orphaned when nothing is in
    // flight; a read issued in the same cycle does not count yet. The output
    // slot refills from the memory first. If the memory is empty, a new return
    // goes straight to the output slot.
    always_comb begin
        busy        = SUMW'(outstanding) + SUMW'(memCount) + SUMW'(outVldR);
        credit      = SUMW'(DEPTH) - busy;
        hst_rdy     = rst & ready & (credit != '0);
        rw_read     = hst_read & hst_rdy;
        retAccept   = rw_vld & (outstanding != '0);
        retOrphan   = rw_vld & (outstanding == '0);
        outFree     = ~outVldR | out_rdy;
        loadFromMem = outFree & (memCount != '0);
        loadBypass  = outFree & (memCount == '0) & retAccept;
        memPush     = retAccept & ~loadBypass;
        newEntry    = '{dout: rw_dout, tag: tagMem[tagRdPtr], serr: rw_serr,
                        derr: rw_derr, padr: rw_padr};
    end

    // Tag storage holds data only, so it needs no reset. The pointers decide
    // which entries are live.
    always_ff @(posedge clk) begin
        if (rw_read) begin
            tagMem[tagWrPtr] <= hst_tag;
        end
    end

    // Tag FIFO pointers and the in-flight count. The count moves by the net
    // result of the issue and the return in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tagWrPtr    <= '0;
            tagRdPtr    <= '0;
            outstanding <= '0;
        end else begin
            if (rw_read) begin
                tagWrPtr <= nextPtr(tagWrPtr);
            end
            if (retAccept) begin
                tagRdPtr <= nextPtr(tagRdPtr);
            end
            case ({rw_read, retAccept})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Response backing memory. The pointers alone decide which entries are
    // live, so the memory needs no reset.
    always_ff @(posedge clk) begin
        if (memPush) begin
            respMem[respWrPtr] <= newEntry;
        end
    end

    // Response queue pointers, output slot and the sticky orphan flag. The
    // output slot is reloaded only when it is empty or being consumed, so
    // out_* stays stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            respWrPtr <= '0;
            respRdPtr <= '0;
            memCount  <= '0;
            outVldR   <= 1'b0;
            outReg    <= '0;
            orphanR   <= 1'b0;
        end else begin
            if (memPush) begin
                respWrPtr <= nextPtr(respWrPtr);
            end
            if (loadFromMem) begin
                respRdPtr <= nextPtr(respRdPtr);
            end
            case ({memPush, loadFromMem})
                2'b10:   memCount <= memCount + 1'b1;
                2'b01:   memCount <= memCount - 1'b1;
                default: memCount <= memCount;
            endcase
            if (outFree) begin
                if (loadFromMem) begin
                    outReg  <= respMem[respRdPtr];
                    outVldR <= 1'b1;
                end else if (loadBypass) begin
                    outReg  <= newEntry;
                    outVldR <= 1'b1;
                end else begin
                    outVldR <= 1'b0;
                end
            end
            if (retOrphan) begin
                orphanR <= 1'b1;
            end
        end
    end

`ifdef ALGO_RDQ_ERRCNT_EN
    logic [15:0] serrCntR;
    logic [15:0] derrCntR;

    // Error counters advance only on returns that are actually queued.
    // Orphaned returns are discarded and not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            serrCntR <= '0;
            derrCntR <= '0;
        end else begin
            if (retAccept && rw_serr && (serrCntR != 16'hFFFF)) begin
                serrCntR <= serrCntR + 16'd1;
            end
            if (retAccept && rw_derr && (derrCntR != 16'hFFFF)) begin
                derrCntR <= derrCntR + 16'd1;
            end
        end
    end

    assign serr_cnt = serrCntR;
    assign derr_cnt = derrCntR;
`else
    assign serr_cnt = '0;
    assign derr_cnt = '0;
`endif

    assign out_vld  = outVldR;
    assign out_dout = outReg.dout;
    assign out_tag  = outReg.tag;
    assign out_serr = outReg.serr;
    assign out_derr = outReg.derr;
    assign out_padr = outReg.padr;
    assign orphan   = orphanR;

endmodule

// File: doc/algo_1rw1w_a107_rdq.md
ALGO_1RW1W_A107_RDQ -- requirements
Module: algo_1rw1w_a107_rdq

Interface
REQ-001 SHALL have parameters (name, default, meaning): WIDTH 32 data width; BITPADR 17 physical-address width; DEPTH 8 response-queue entries; BITDPTH 3 log2(DEPTH); TAGW 4 host tag width.
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk input 1 clock; rst input 1 async active-low reset.
REQ-003 SHALL have the following host request ports: ready input 1 memory-ready from the 1rw1w top; hst_read input 1 read request; hst_tag input TAGW request tag; hst_rdy output 1 request accepted this cycle when high.
REQ-004 SHALL have the following memory-side ports: rw_read output 1 read issue; rw_vld input 1 read return; rw_dout input WIDTH return data; rw_serr input 1 single-bit error; rw_derr input 1 double-bit error; rw_padr input BITPADR physical address.
REQ-005 SHALL have the following consumer ports: out_vld output 1; out_rdy input 1; out_dout output WIDTH; out_tag output TAGW; out_serr output 1; out_derr output 1; out_padr output BITPADR.
REQ-006 SHALL have the following status ports: orphan output 1 sticky "return with no outstanding tag"; serr_cnt output 16; derr_cnt output 16.

Function
REQ-007 SHALL compute credit = DEPTH - (outstanding + queued), where outstanding counts issued-but-unreturned reads and queued counts entries held in the response queue.
REQ-008 SHALL drive hst_rdy = ready & (credit != 0), combinationally; SHALL drive rw_read = hst_read & hst_rdy.
REQ-009 SHALL push hst_tag into a DEPTH-entry in-order tag FIFO on every cycle in which rw_read is high.
REQ-010 SHALL, on rw_vld, pop the oldest tag and write {rw_dout, tag, rw_serr, rw_derr, rw_padr} into the response queue in the same cycle.
REQ-011 SHALL present the queue head on out_* registered, so that out_vld rises the cycle after rw_vld when the queue was empty (latency 1).
REQ-012 SHALL pop the response queue head when out_vld & out_rdy, and SHALL hold out_* stable while out_vld & !out_rdy.
REQ-013 SHALL allow, in one cycle, an issue, a return and a consumer pop together; the counters SHALL update by the net amount, with no lost or duplicated entry.
REQ-014 SHALL never overflow either FIFO, since credit gating guarantees outstanding + queued <= DEPTH; read/write pointers SHALL wrap modulo DEPTH.
REQ-015 SHALL, on rw_vld when outstanding == 0, set orphan, discard the return, and leave all counters and the queue unchanged.
REQ-016 SHALL make orphan sticky until reset.
REQ-017 SHALL ignore hst_read and issue nothing when ready is low, while returns and consumer pops continue.

Reset
REQ-018 SHALL, on rst low, asynchronously clear pointers, outstanding, queued, orphan, serr_cnt, derr_cnt, out_vld and out_* data (all zero); hst_rdy and rw_read SHALL read 0 during reset.
REQ-019 SHALL, on reset asserted mid-operation, drop all in-flight tags and queued responses, and SHALL restore credit to DEPTH once reset is released.

Configuration
REQ-020 SHALL, with macro ALGO_RDQ_ERRCNT_EN defined, increment serr_cnt / derr_cnt by 1 for each queued return with rw_serr / rw_derr set, saturating at 16'hFFFF.
REQ-021 SHALL, without ALGO_RDQ_ERRCNT_EN, tie serr_cnt and derr_cnt to 0 and include no counter registers; out_serr and out_derr SHALL still pass through.

Verification
REQ-022 SHALL cover a single read: ready=1, hst_read with tag 5, rw_vld 2 cycles later with dout 0xDEADBEEF -> out_vld 1 cycle later, out_tag 5, out_dout 0xDEADBEEF; credit returns to 8 after the pop.
REQ-023 SHALL cover credit exhaustion: out_rdy=0, 8 reads issued and returned -> hst_rdy=0 on the 9th request; one pop -> hst_rdy=1 in the next cycle.
REQ-024 SHALL cover simultaneous events: at occupancy 4, issue + return + pop in the same cycle -> queued stays 4, outstanding unchanged, output order preserved (tags 0..7 come out in order).
REQ-025 SHALL cover an orphan return: rw_vld with nothing outstanding -> orphan=1, out_vld stays 0, orphan stays 1 for 100 cycles.
REQ-026 SHALL cover errors: with ALGO_RDQ_ERRCNT_EN defined, 3 returns with serr and 1 with derr -> serr_cnt=3, derr_cnt=1; with serr_cnt forced to 0xFFFE and 3 more serr returns -> serr_cnt=0xFFFF.
REQ-027 SHALL cover reset mid-flight: 3 outstanding and 2 queued, rst pulsed low -> out_vld=0 immediately, hst_rdy=1 after release, and late rw_vld returns set orphan.
